// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and widths for the on-chip trace buffer
package trace_pkg;

   localparam int TRACE_STATE_W = 5;
   localparam int TRACE_DATA_W  = 64;
   localparam int TRACE_STAMP_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DONE
   } trace_state_e;

   typedef struct packed {
      logic [TRACE_STAMP_W-1:0] stamp;
      logic [TRACE_STATE_W-1:0] state;
      logic [TRACE_DATA_W-1:0]  data;
   } trace_entry_t;

   localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

   // Cycle stamp holds at all-ones instead of wrapping back to zero.
   function automatic logic [TRACE_STAMP_W-1:0] stamp_inc(input logic [TRACE_STAMP_W-1:0] s);
      return (&s) ? s : s + TRACE_STAMP_W'(1);
   endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - entry storage: one synchronous write port, one asynchronous read port
module trace_ram
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = TRACE_ENTRY_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - records timestamped control-state changes into a circular buffer
// and drains them oldest-first over a valid/ready read port once capture stops.
module trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int STATE_W      = TRACE_STATE_W,
   parameter int DATA_W       = TRACE_DATA_W,
   parameter int STAMP_W      = TRACE_STAMP_W,
   parameter bit STOP_ON_FULL = 1'b1,
   localparam int PTR_W       = $clog2(DEPTH),
   localparam int CNT_W       = PTR_W + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               arm,
   input  logic               trigger_en,
   input  logic [STATE_W-1:0] trigger_state,
   input  logic [STATE_W-1:0] state_in,
   input  logic [DATA_W-1:0]  data_in,
   output logic               capturing,
   output logic               done,
   output logic               overflow,
   output logic [CNT_W-1:0]   count,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [STAMP_W-1:0] rd_stamp,
   output logic [STATE_W-1:0] rd_state,
   output logic [DATA_W-1:0]  rd_data
);

   trace_state_e       fsm_q, fsm_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [STAMP_W-1:0] stamp_q, stamp_d;
   logic [STATE_W-1:0] prev_state_q, prev_state_d;
   logic               overflow_q, overflow_d;

   logic               ram_we;
   logic [PTR_W-1:0]   ram_waddr;
   trace_entry_t       wr_entry;
   trace_entry_t       rd_entry;
   logic               full;

   trace_ram #(
      .DEPTH (DEPTH),
      .W     (TRACE_ENTRY_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign full     = (count_q == CNT_W'(DEPTH));
   assign rd_valid = (fsm_q == DONE) && (count_q != '0);

   always_comb begin
      fsm_d        = fsm_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      stamp_d      = stamp_q;
      prev_state_d = prev_state_q;
      overflow_d   = overflow_q;
      ram_we       = 1'b0;
      ram_waddr    = wr_ptr_q;
      wr_entry     = '{stamp: stamp_q, state: state_in, data: data_in};

      case (fsm_q)
         CAPTURE: begin
            prev_state_d = state_in;
            stamp_d      = stamp_inc(stamp_q);
            if (state_in != prev_state_q) begin
               if (!full) begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  count_d  = count_q + CNT_W'(1);
               end else if (STOP_ON_FULL) begin
                  overflow_d = 1'b1;
                  fsm_d      = DONE;
               end else begin
                  // Overwrite the oldest entry and slide the read window with it.
                  ram_we     = 1'b1;
                  wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                  rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                  overflow_d = 1'b1;
               end
            end
            if (trigger_en && (state_in == trigger_state)) begin
               fsm_d = DONE;
            end
         end
         DONE: begin
            if (rd_valid && rd_ready) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               count_d  = count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  fsm_d = IDLE;
               end
            end
         end
         default: begin
         end
      endcase

      // Arm restarts from any state and always lands its own entry at slot 0.
      if (arm) begin
         fsm_d          = CAPTURE;
         wr_ptr_d       = PTR_W'(1);
         rd_ptr_d       = '0;
         count_d        = CNT_W'(1);
         overflow_d     = 1'b0;
         stamp_d        = STAMP_W'(1);
         prev_state_d   = state_in;
         ram_we         = 1'b1;
         ram_waddr      = '0;
         wr_entry.stamp = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q        <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         stamp_q      <= '0;
         prev_state_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         stamp_q      <= stamp_d;
         prev_state_q <= prev_state_d;
         overflow_q   <= overflow_d;
      end
   end

   assign capturing = (fsm_q == CAPTURE);
   assign done      = (fsm_q == DONE);
   assign overflow  = overflow_q;
   assign count     = count_q;
   assign rd_stamp  = rd_valid ? rd_entry.stamp : '0;
   assign rd_state  = rd_valid ? rd_entry.state : '0;
   assign rd_data   = rd_valid ? rd_entry.data  : '0;

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - two DEPTH=4 trace buffers (stop-on-full and overwrite) on shared stimulus
module tb_trace_buffer;

   localparam int EW = 16 + 5 + 64;

   logic        clk = 1'b0;
   logic        reset, arm, trigger_en, rd_ready;
   logic [4:0]  trigger_state, state_in;
   logic [63:0] data_in;

   logic        capturing_o [2];
   logic        done_o      [2];
   logic        overflow_o  [2];
   logic        rd_valid_o  [2];
   logic [2:0]  count_o     [2];
   logic [15:0] rd_stamp_o  [2];
   logic [4:0]  rd_state_o  [2];
   logic [63:0] rd_data_o   [2];

   always #5 clk = ~clk;

   trace_buffer #(.DEPTH(4), .STOP_ON_FULL(1'b1)) u_dut_stop (
      .clk(clk), .reset(reset), .arm(arm), .trigger_en(trigger_en),
      .trigger_state(trigger_state), .state_in(state_in), .data_in(data_in),
      .capturing(capturing_o[0]), .done(done_o[0]), .overflow(overflow_o[0]),
      .count(count_o[0]), .rd_valid(rd_valid_o[0]), .rd_ready(rd_ready),
      .rd_stamp(rd_stamp_o[0]), .rd_state(rd_state_o[0]), .rd_data(rd_data_o[0])
   );

   trace_buffer #(.DEPTH(4), .STOP_ON_FULL(1'b0)) u_dut_wrap (
      .clk(clk), .reset(reset), .arm(arm), .trigger_en(trigger_en),
      .trigger_state(trigger_state), .state_in(state_in), .data_in(data_in),
      .capturing(capturing_o[1]), .done(done_o[1]), .overflow(overflow_o[1]),
      .count(count_o[1]), .rd_valid(rd_valid_o[1]), .rd_ready(rd_ready),
      .rd_stamp(rd_stamp_o[1]), .rd_state(rd_state_o[1]), .rd_data(rd_data_o[1])
   );

   int tests = 0;
   int fails = 0;

   // Reference: mode 0 idle, 1 capturing, 2 readout; held entries as a FIFO queue.
   int          mode  [2];
   bit          ovf   [2];
   int          stamp [2];
   logic [4:0]  prev  [2];
   logic [EW-1:0] q0[$];
   logic [EW-1:0] q1[$];

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [EW-1:0] qfront(input int k);
      return (k == 0) ? q0[0] : q1[0];
   endfunction

   task automatic qpush(input int k, input logic [EW-1:0] e);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic qpop(input int k);
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
   endtask

   task automatic qclear(input int k);
      if (k == 0) q0.delete(); else q1.delete();
   endtask

   task automatic chk(input string tag, input int k, input logic [95:0] obs, input logic [95:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            qclear(k);
            mode[k] = 0; ovf[k] = 1'b0; stamp[k] = 0; prev[k] = '0;
         end else if (arm) begin
            qclear(k);
            qpush(k, {16'd0, state_in, data_in});
            mode[k] = 1; ovf[k] = 1'b0; stamp[k] = 1; prev[k] = state_in;
         end else if (mode[k] == 1) begin
            if (state_in != prev[k]) begin
               if (qsize(k) == 4) begin
                  ovf[k] = 1'b1;
                  if (k == 0) begin
                     mode[k] = 2;
                  end else begin
                     qpop(k);
                     qpush(k, {16'(stamp[k]), state_in, data_in});
                  end
               end else begin
                  qpush(k, {16'(stamp[k]), state_in, data_in});
               end
            end
            if (trigger_en && state_in == trigger_state) mode[k] = 2;
            prev[k] = state_in;
            if (stamp[k] < 65535) stamp[k]++;
         end else if (mode[k] == 2) begin
            if (rd_ready && qsize(k) > 0) begin
               qpop(k);
               if (qsize(k) == 0) mode[k] = 0;
            end
         end
      end
   endtask

   task automatic check_model();
      bit v;
      for (int k = 0; k < 2; k++) begin
         v = (mode[k] == 2) && (qsize(k) > 0);
         chk("capturing", k, 96'(capturing_o[k]), 96'(mode[k] == 1));
         chk("done", k, 96'(done_o[k]), 96'(mode[k] == 2));
         chk("overflow", k, 96'(overflow_o[k]), 96'(ovf[k]));
         chk("count", k, 96'(count_o[k]), 96'(qsize(k)));
         chk("rd_valid", k, 96'(rd_valid_o[k]), 96'(v));
         if (v) chk("rd_entry", k, 96'({rd_stamp_o[k], rd_state_o[k], rd_data_o[k]}), 96'(qfront(k)));
      end
   endtask

   task automatic tick();
      #1;
      check_model();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input bit a, input logic [4:0] st, input bit rdy);
      arm      = a;
      state_in = st;
      rd_ready = rdy;
      data_in  = {$urandom, $urandom};
      tick();
   endtask

   initial begin
      int exp_stamp [3];
      exp_stamp[0] = 0; exp_stamp[1] = 1; exp_stamp[2] = 3;

      reset = 1'b1; arm = 1'b0; trigger_en = 1'b0; trigger_state = '0;
      state_in = '0; data_in = '0; rd_ready = 1'b0;
      repeat (2) begin
         @(posedge clk);
         model_step();
      end
      #1;
      reset = 1'b0;

      // Reset asserted for two cycles in the middle of a capture
      drive(1'b1, 5'd3, 1'b0);
      drive(1'b0, 5'd4, 1'b0);
      drive(1'b0, 5'd6, 1'b0);
      reset = 1'b1;
      drive(1'b0, 5'd7, 1'b0);
      drive(1'b0, 5'd8, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("rst_capturing", k, 96'(capturing_o[k]), 96'(0));
         chk("rst_done", k, 96'(done_o[k]), 96'(0));
         chk("rst_count", k, 96'(count_o[k]), 96'(0));
         chk("rst_overflow", k, 96'(overflow_o[k]), 96'(0));
         chk("rst_rd_valid", k, 96'(rd_valid_o[k]), 96'(0));
         chk("rst_rd", k, 96'({rd_stamp_o[k], rd_state_o[k], rd_data_o[k]}), 96'(0));
      end

      // Trigger on state 2, unchanged state 1 not recorded
      trigger_en = 1'b1; trigger_state = 5'd2;
      drive(1'b1, 5'd0, 1'b0);
      drive(1'b0, 5'd1, 1'b0);
      drive(1'b0, 5'd1, 1'b0);
      drive(1'b0, 5'd2, 1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("t2_done", k, 96'(done_o[k]), 96'(1));
         chk("t2_count", k, 96'(count_o[k]), 96'(3));
      end
      for (int i = 0; i < 3; i++) begin
         chk("t2_stamp", 0, 96'(rd_stamp_o[0]), 96'(exp_stamp[i]));
         chk("t2_state", 0, 96'(rd_state_o[0]), 96'(i));
         drive(1'b0, 5'd2, 1'b1);
      end
      chk("t2_idle_done", 0, 96'(done_o[0]), 96'(0));
      chk("t2_idle_cap", 0, 96'(capturing_o[0]), 96'(0));

      // Fill past DEPTH: stop instance drops, wrap instance keeps the newest four
      trigger_state = 5'd5;
      drive(1'b1, 5'd0, 1'b0);
      for (int s = 1; s <= 5; s++) drive(1'b0, 5'(s), 1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("full_done", k, 96'(done_o[k]), 96'(1));
         chk("full_count", k, 96'(count_o[k]), 96'(4));
         chk("full_overflow", k, 96'(overflow_o[k]), 96'(1));
      end
      for (int i = 0; i < 4; i++) begin
         chk("stop_state", 0, 96'(rd_state_o[0]), 96'(i));
         chk("wrap_state", 1, 96'(rd_state_o[1]), 96'(i + 2));
         drive(1'b0, 5'd5, 1'b1);
      end

      // Backpressure pattern 1,0,0,1
      trigger_state = 5'd2;
      drive(1'b1, 5'd0, 1'b0);
      drive(1'b0, 5'd1, 1'b0);
      drive(1'b0, 5'd2, 1'b0);
      drive(1'b0, 5'd2, 1'b1);
      chk("bp_hold0", 0, 96'(rd_state_o[0]), 96'(1));
      drive(1'b0, 5'd2, 1'b0);
      chk("bp_hold1", 0, 96'(rd_state_o[0]), 96'(1));
      drive(1'b0, 5'd2, 1'b0);
      chk("bp_hold2", 0, 96'(rd_state_o[0]), 96'(1));
      drive(1'b0, 5'd2, 1'b1);
      chk("bp_count", 0, 96'(count_o[0]), 96'(1));
      chk("bp_state", 0, 96'(rd_state_o[0]), 96'(2));

      // Arm during readout after one beat
      drive(1'b1, 5'd0, 1'b0);
      drive(1'b0, 5'd1, 1'b0);
      drive(1'b0, 5'd2, 1'b0);
      drive(1'b0, 5'd2, 1'b1);
      trigger_state = 5'd7;
      drive(1'b1, 5'd7, 1'b0);
      for (int k = 0; k < 2; k++) begin
         chk("rearm_valid", k, 96'(rd_valid_o[k]), 96'(0));
         chk("rearm_cap", k, 96'(capturing_o[k]), 96'(1));
         chk("rearm_count", k, 96'(count_o[k]), 96'(1));
         chk("rearm_ovf", k, 96'(overflow_o[k]), 96'(0));
      end
      drive(1'b0, 5'd7, 1'b0);
      chk("rearm_done", 0, 96'(done_o[0]), 96'(1));
      chk("rearm_stamp", 0, 96'(rd_stamp_o[0]), 96'(0));
      chk("rearm_state", 0, 96'(rd_state_o[0]), 96'(7));
      drive(1'b0, 5'd7, 1'b1);

      // Randomized traffic against the reference
      repeat (600) begin
         trigger_en    = ($urandom_range(0, 3) == 0);
         trigger_state = 5'($urandom_range(0, 3));
         drive($urandom_range(0, 19) == 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Stamp saturation at all-ones
      trigger_en = 1'b0;
      drive(1'b1, 5'd0, 1'b0);
      repeat (65540) drive(1'b0, 5'd0, 1'b0);
      trigger_en = 1'b1; trigger_state = 5'd1;
      drive(1'b0, 5'd1, 1'b0);
      drive(1'b0, 5'd1, 1'b1);
      chk("sat_stamp", 0, 96'(rd_stamp_o[0]), 96'(16'hFFFF));
      chk("sat_state", 0, 96'(rd_state_o[0]), 96'(1));
      drive(1'b0, 5'd1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
